// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the run controller: state encoding, default budgets
// and the cycle counter width.
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_DONE    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_e;

    localparam int unsigned DEF_MAX_CYCLES   = 500000;
    localparam int unsigned DEF_DRAIN_CYCLES = 4;
    localparam int          CNT_W            = 32;

endpackage

// File: rtl/run_ctrl_cycle_counter.sv
// Run-cycle counter with synchronous clear, count enable and a budget-limit
// match flag that fires on the edge that will bring the count to LIMIT.
module cycle_counter
    import run_ctrl_pkg::*;
#(
    parameter int unsigned LIMIT = DEF_MAX_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o,
    output logic             atLimit_o
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count_o   = count_q;
    assign atLimit_o = en_i && (count_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/run_ctrl.sv
// Run controller: launches the pipeline, watches for halt or budget exhaustion,
// drains, and reports. Define RUN_CTRL_SIM_REPORT_EN for the simulation report.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int unsigned MAX_CYCLES   = DEF_MAX_CYCLES,
    parameter int unsigned DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clear,
    input  logic             isHalt,
    input  logic [15:0]      ret_val,
    output logic             cpu_run,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [15:0]      result,
    output logic [CNT_W-1:0] cycles
);

    state_e           state_q;
    logic [CNT_W-1:0] drainCnt_q;
    logic [15:0]      result_q;
    logic             cpuRun_q;
    logic             busy_q;
    logic             done_q;
    logic             timeout_q;
    logic             cntClear;
    logic             atLimit;

    assign cntClear = (state_q == ST_IDLE) && start;

    cycle_counter #(
        .LIMIT (MAX_CYCLES)
    ) u_cycle_counter (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (cntClear),
        .en_i      (state_q == ST_RUN),
        .count_o   (cycles),
        .atLimit_o (atLimit)
    );

    // Output flags are updated alongside each transition so they are pure registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            drainCnt_q <= '0;
            result_q   <= '0;
            cpuRun_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q    <= ST_RUN;
                        result_q   <= '0;
                        drainCnt_q <= CNT_W'(DRAIN_CYCLES);
                        cpuRun_q   <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (isHalt) begin
                        result_q <= ret_val;
                        cpuRun_q <= 1'b0;
                        if (DRAIN_CYCLES > 0) begin
                            state_q <= ST_DRAIN;
                        end else begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else if (atLimit) begin
                        state_q   <= ST_TIMEOUT;
                        cpuRun_q  <= 1'b0;
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    drainCnt_q <= drainCnt_q - CNT_W'(1);
                    if (drainCnt_q == CNT_W'(1)) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (clear) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b0;
                    end
                end
                ST_TIMEOUT: begin
                    if (clear) begin
                        state_q   <= ST_IDLE;
                        timeout_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    cpuRun_q  <= 1'b0;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                    timeout_q <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_run = cpuRun_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign timeout = timeout_q;
    assign result  = result_q;

`ifdef RUN_CTRL_SIM_REPORT_EN
    logic doneSeen_q;
    logic timeoutSeen_q;

    // Reports once on the first cycle spent in DONE or TIMEOUT.
    always @(posedge clk) begin
        doneSeen_q    <= done_q;
        timeoutSeen_q <= timeout_q;
        if (!rst && done_q && !doneSeen_q) begin
            $display("Finished with << %0d >>", result_q);
            $finish;
        end
        if (!rst && timeout_q && !timeoutSeen_q) begin
            $display("ran for %0d cycles", cycles);
            $finish;
        end
    end
`else
`endif

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: two instances (MAX=20/DRAIN=4 and
// MAX=64/DRAIN=0) share stimulus and are compared against a behavioural model.
module tb_run_ctrl;

    localparam int unsigned MAX_A   = 20;
    localparam int unsigned DRAIN_A = 4;
    localparam int unsigned MAX_B   = 64;
    localparam int unsigned DRAIN_B = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic        isHalt = 1'b0;
    logic [15:0] retVal = '0;

    logic [1:0]  cpuRunO;
    logic [1:0]  busyO;
    logic [1:0]  doneO;
    logic [1:0]  timeoutO;
    logic [15:0] resultO [2];
    logic [31:0] cyclesO [2];

    int total = 0;
    int bad = 0;

    bit          mRunning [2];
    int          mDrainLeft [2];
    bit          mDone [2];
    bit          mTimeout [2];
    int unsigned mCycles [2];
    logic [15:0] mResult [2];

    typedef struct {
        bit          s;
        bit          c;
        bit          h;
        logic [15:0] rv;
        bit          eRun;
        bit          eBusy;
        bit          eDone;
        bit          eTo;
        logic [15:0] eRes;
        int unsigned eCyc;
    } vec_t;

    vec_t vecs [13];

    always #5 clk = ~clk;

    run_ctrl #(.MAX_CYCLES(MAX_A), .DRAIN_CYCLES(DRAIN_A)) dutA (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .isHalt(isHalt),
        .ret_val(retVal), .cpu_run(cpuRunO[0]), .busy(busyO[0]), .done(doneO[0]),
        .timeout(timeoutO[0]), .result(resultO[0]), .cycles(cyclesO[0])
    );

    run_ctrl #(.MAX_CYCLES(MAX_B), .DRAIN_CYCLES(DRAIN_B)) dutB (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .isHalt(isHalt),
        .ret_val(retVal), .cpu_run(cpuRunO[1]), .busy(busyO[1]), .done(doneO[1]),
        .timeout(timeoutO[1]), .result(resultO[1]), .cycles(cyclesO[1])
    );

    function automatic int unsigned maxOf(int d);
        return (d == 0) ? MAX_A : MAX_B;
    endfunction

    function automatic int unsigned drainOf(int d);
        return (d == 0) ? DRAIN_A : DRAIN_B;
    endfunction

    // Reference model: one call per clock edge, following the run/drain/report rules.
    task automatic modelStep(input int d, input bit s, input bit c, input bit h, input logic [15:0] rv);
        if (mDone[d] || mTimeout[d]) begin
            if (c) begin
                mDone[d]    = 1'b0;
                mTimeout[d] = 1'b0;
            end
        end else if (mRunning[d]) begin
            mCycles[d] = mCycles[d] + 1;
            if (h) begin
                mResult[d]  = rv;
                mRunning[d] = 1'b0;
                if (drainOf(d) == 0) mDone[d] = 1'b1;
                else mDrainLeft[d] = int'(drainOf(d));
            end else if (mCycles[d] == maxOf(d)) begin
                mRunning[d] = 1'b0;
                mTimeout[d] = 1'b1;
            end
        end else if (mDrainLeft[d] > 0) begin
            mDrainLeft[d] = mDrainLeft[d] - 1;
            if (mDrainLeft[d] == 0) mDone[d] = 1'b1;
        end else if (s) begin
            mRunning[d] = 1'b1;
            mCycles[d]  = 0;
            mResult[d]  = '0;
        end
    endtask

    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            mRunning[d]   = 1'b0;
            mDrainLeft[d] = 0;
            mDone[d]      = 1'b0;
            mTimeout[d]   = 1'b0;
            mCycles[d]    = 0;
            mResult[d]    = '0;
        end
    endtask

    task automatic checkVal(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s dut%0d at %0t: got=%0h want=%0h", name, d, $time, act, exp);
        end
    endtask

    task automatic checkOutput();
        for (int d = 0; d < 2; d++) begin
            checkVal("cpu_run", d, 32'(cpuRunO[d]), 32'(mRunning[d]));
            checkVal("busy", d, 32'(busyO[d]), 32'(mRunning[d] || (mDrainLeft[d] > 0)));
            checkVal("done", d, 32'(doneO[d]), 32'(mDone[d]));
            checkVal("timeout", d, 32'(timeoutO[d]), 32'(mTimeout[d]));
            checkVal("result", d, 32'(resultO[d]), 32'(mResult[d]));
            checkVal("cycles", d, cyclesO[d], mCycles[d]);
        end
    endtask

    // Drives inputs on the falling edge, steps the model at the rising edge, checks on the next falling edge.
    task automatic applyStimulus(input bit s, input bit c, input bit h, input logic [15:0] rv);
        start  = s;
        clear  = c;
        isHalt = h;
        retVal = rv;
        @(posedge clk);
        for (int d = 0; d < 2; d++) modelStep(d, s, c, h, rv);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic doReset();
        start  = 1'b0;
        clear  = 1'b0;
        isHalt = 1'b0;
        rst    = 1'b1;
        #1;
        modelReset();
        checkOutput();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0,  0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0,  1};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0,  2};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0,  3};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 16'h002A, 1'b0, 1'b1, 1'b0, 1'b0, 16'd42, 4};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 16'h0055, 1'b0, 1'b1, 1'b0, 1'b0, 16'd42, 4};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'd42, 4};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'd42, 4};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'd42, 4};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 16'h0007, 1'b0, 1'b0, 1'b1, 1'b0, 16'd42, 4};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'd42, 4};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'd42, 4};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0,  0};

        @(negedge clk);
        doReset();

        // Directed table against the MAX=20/DRAIN=4 instance.
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].s, vecs[i].c, vecs[i].h, vecs[i].rv);
            checkVal("vec_cpu_run", 0, 32'(cpuRunO[0]), 32'(vecs[i].eRun));
            checkVal("vec_busy", 0, 32'(busyO[0]), 32'(vecs[i].eBusy));
            checkVal("vec_done", 0, 32'(doneO[0]), 32'(vecs[i].eDone));
            checkVal("vec_timeout", 0, 32'(timeoutO[0]), 32'(vecs[i].eTo));
            checkVal("vec_result", 0, 32'(resultO[0]), 32'(vecs[i].eRes));
            checkVal("vec_cycles", 0, cyclesO[0], vecs[i].eCyc);
        end

        // Reset in the middle of a run at cycles=37, then restart.
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 37; i++) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
        checkVal("mid_run_cycles", 1, cyclesO[1], 32'd37);
        checkVal("mid_run_cpu_run", 1, 32'(cpuRunO[1]), 32'd1);
        doReset();
        checkVal("post_reset_cycles", 1, cyclesO[1], 32'd0);
        checkVal("post_reset_busy", 1, 32'(busyO[1]), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
        checkVal("restart_cycles", 1, cyclesO[1], 32'd1);

        // Halt with 0x2A after 10 RUN cycles, then drain.
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h002A);
        checkVal("halt_cpu_run", 0, 32'(cpuRunO[0]), 32'd0);
        checkVal("halt_result", 0, 32'(resultO[0]), 32'd42);
        checkVal("halt_cycles", 0, cyclesO[0], 32'd10);
        checkVal("nodrain_done", 1, 32'(doneO[1]), 32'd1);
        k = 0;
        while (!doneO[0] && k < 20) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
            k++;
        end
        checkVal("drain_latency", 0, 32'(k), 32'd4);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h1234);
        checkVal("done_halt_result", 0, 32'(resultO[0]), 32'd42);
        checkVal("done_halt_result", 1, 32'(resultO[1]), 32'd42);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
        checkVal("clear_done", 0, 32'(doneO[0]), 32'd0);
        checkVal("clear_keep_cycles", 0, cyclesO[0], 32'd10);
        checkVal("clear_keep_result", 0, 32'(resultO[0]), 32'd42);

        // Budget exhaustion with no halt.
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
        k = 0;
        while (!timeoutO[0] && k < 40) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
            k++;
        end
        checkVal("timeout_latency", 0, 32'(k), 32'(MAX_A));
        checkVal("timeout_cycles", 0, cyclesO[0], 32'(MAX_A));
        checkVal("timeout_cpu_run", 0, 32'(cpuRunO[0]), 32'd0);
        checkVal("timeout_done", 0, 32'(doneO[0]), 32'd0);

        // Halt on the last budget cycle: halt takes priority.
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 19; i++) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h00BE);
        checkVal("edge_halt_timeout", 0, 32'(timeoutO[0]), 32'd0);
        checkVal("edge_halt_cycles", 0, cyclesO[0], 32'd20);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
        checkVal("edge_halt_done", 0, 32'(doneO[0]), 32'd1);
        checkVal("edge_halt_timeout2", 0, 32'(timeoutO[0]), 32'd0);

        // Randomised traffic against the model.
        doReset();
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 15) == 0), 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Run controller for the pipeline CPU. It launches execution, gates the pipeline's run enable, and counts executed cycles against a watchdog budget. On halt it drains the pipeline for a fixed number of cycles, then reports the return value. When the budget is exhausted first, it stops the core and reports a timeout. It sits between the testbench or host control logic and the pipeline top level, and it replaces ad-hoc halt and cycle monitoring.

## Interface
- `MAX_CYCLES`, default 500000: watchdog budget in RUN cycles. Must be ≥ 1.
- `DRAIN_CYCLES`, default 4: cycles to hold after halt before reporting. 0 means report immediately.
- `clk`  in  1  system clock; all state updates on the posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle launch pulse. Honoured only in IDLE.
- `clear`  in  1  acknowledge. Returns DONE or TIMEOUT to IDLE.
- `isHalt`  in  1  halt indication from the pipeline writeback stage.
- `ret_val`  in  16  return value from the pipeline, valid when `isHalt` is high.
- `cpu_run`  out  1  pipeline enable. High only in RUN.
- `busy`  out  1  high in RUN or DRAIN.
- `done`  out  1  level, high in DONE.
- `timeout`  out  1  level, high in TIMEOUT.
- `result`  out  16  `ret_val` captured on the halt cycle.
- `cycles`  out  32  RUN-cycle count for the current or last run.

## Operation
- States: IDLE, RUN, DRAIN, DONE, TIMEOUT.
- **IDLE**:
  - `start` → RUN.
  - On the same edge, `cycles` is cleared to 0, `result` is cleared to 0, and the drain counter is loaded with `DRAIN_CYCLES`.
- **RUN**: `cycles` increments by 1 every cycle.
  - `isHalt` high → capture `ret_val` into `result`. Go to DRAIN if `DRAIN_CYCLES` > 0, otherwise to DONE.
  - No halt, and `cycles` == `MAX_CYCLES`−1 on this edge → TIMEOUT. `cycles` ends at `MAX_CYCLES`.
  - `isHalt` and the budget boundary in the same cycle: halt wins.
- **DRAIN**:
  - The drain counter decrements each cycle; at 1 it goes to DONE.
  - `isHalt` and `ret_val` are ignored. `cycles` is frozen.
- **DONE / TIMEOUT**:
  - Outputs hold.
  - `clear` → IDLE. `cycles` and `result` are retained until the next `start`.
- `start` outside IDLE is ignored. `clear` outside DONE or TIMEOUT is ignored.
- `start` and `clear` together in DONE: `clear` is taken and `start` is dropped. A new `start` is required in IDLE.
- `cycles` is 32-bit unsigned and never wraps, because `MAX_CYCLES` < 2^32 is required.
- Reset, including mid-run: state → IDLE and all outputs → 0.

## Timing
- All outputs are registered and decoded from the state register. There are no combinational paths from inputs to outputs.
- `start` sampled at edge N → `cpu_run` = 1 from cycle N+1. The first increment of `cycles` happens at edge N+1.
- `isHalt` sampled at edge H → `cpu_run` = 0 from cycle H+1. `result` is valid from cycle H+1.
- `done` rises at cycle H+1+`DRAIN_CYCLES`.
- Timeout: with no halt, `timeout` rises exactly `MAX_CYCLES` cycles after `cpu_run` rises, and `cpu_run` falls on the same cycle.
- `clear` at edge C → `done` or `timeout` is 0 from cycle C+1.

## Configuration
- `RUN_CTRL_SIM_REPORT_EN` defined:
  - On entry to DONE, the simulation-only block prints `Finished with << %0d >>` with `result`, then calls `$finish`.
  - On entry to TIMEOUT, it prints `ran for %0d cycles` with `cycles`, then calls `$finish`.
- Not defined: no system tasks are present and the block is fully synthesizable. Register behaviour is identical in both builds.

## Structure
- Shared package or include `run_ctrl_pkg` holds:
  - the state encoding constants (3-bit);
  - the default `MAX_CYCLES` and `DRAIN_CYCLES` values;
  - the counter width constant (32).
- Sub-module `cycle_counter`: a 32-bit counter with clear, enable and limit-match output. It drives `cycles` and the timeout condition.
- The FSM, the drain counter and the result capture stay in `run_ctrl`.

## Test plan
- Reset mid-RUN (`cycles` = 37), then `rst` pulse → all outputs 0 and state IDLE. A `start` afterwards restarts with `cycles` counting from 0.
- `start`; `isHalt` with `ret_val` = 16'h002A after 10 RUN cycles; `DRAIN_CYCLES` = 4:
  - `cpu_run` falls on the next cycle;
  - `result` = 42 and `cycles` = 10;
  - `done` rises 5 cycles after the halt edge.
- `MAX_CYCLES` = 20 with no halt → `timeout` = 1 and `cycles` = 20 exactly 20 cycles after `cpu_run` rises; `done` stays 0.
- `MAX_CYCLES` = 20 with `isHalt` on the 20th RUN cycle → DONE path taken; `timeout` never asserts.
- `DRAIN_CYCLES` = 0 → `done` rises on the cycle after the halt edge. An extra `isHalt` pulse during DONE leaves `result` unchanged.
- `start` asserted during RUN and DRAIN → no effect. `clear` in DONE → IDLE, with `cycles` and `result` retained until the next `start`.
